// File: rtl/time_keeper.sv
// 24-hour timekeeping core: 1 Hz prescaler, hh:mm:ss counter and two-button time setting.
// Define TIME_DEBOUNCE_EN to add a per-button debounce filter of DEBOUNCE_CYCLES samples.
module time_keeper #(
    parameter int CLK_FREQ        = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [1:0] mode,
    output logic       tick
);

    localparam int              PW       = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0]   PCNT_MAX = PW'(CLK_FREQ - 1);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] SET_HOUR = 2'd1;
    localparam logic [1:0] SET_MIN  = 2'd2;
    localparam logic [1:0] SET_SEC  = 2'd3;

    // Left empty on purpose: marks an unsupported parameter set.
    if (CLK_FREQ < 2 || DEBOUNCE_CYCLES < 1) begin : g_invalid_params
    end

    logic [1:0] mode_sync, inc_sync;
    logic       mode_lvl, inc_lvl;
    logic       mode_prev, inc_prev;
    logic       mode_press, inc_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_sync <= '0;
            inc_sync  <= '0;
        end else begin
            mode_sync <= {mode_sync[0], btn_mode};
            inc_sync  <= {inc_sync[0], btn_inc};
        end
    end

`ifdef TIME_DEBOUNCE_EN
    localparam int            DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [DW-1:0] mode_cnt, inc_cnt;

    // The counter runs only while the synchronized level differs from the accepted one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_cnt <= '0;
            inc_cnt  <= '0;
            mode_lvl <= 1'b0;
            inc_lvl  <= 1'b0;
        end else begin
            if (mode_sync[1] == mode_lvl) begin
                mode_cnt <= '0;
            end else if (mode_cnt == DB_LAST) begin
                mode_lvl <= mode_sync[1];
                mode_cnt <= '0;
            end else begin
                mode_cnt <= mode_cnt + 1'b1;
            end

            if (inc_sync[1] == inc_lvl) begin
                inc_cnt <= '0;
            end else if (inc_cnt == DB_LAST) begin
                inc_lvl <= inc_sync[1];
                inc_cnt <= '0;
            end else begin
                inc_cnt <= inc_cnt + 1'b1;
            end
        end
    end
`else
    assign mode_lvl = mode_sync[1];
    assign inc_lvl  = inc_sync[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
        end else begin
            mode_prev <= mode_lvl;
            inc_prev  <= inc_lvl;
        end
    end

    assign mode_press = mode_lvl & ~mode_prev;
    assign inc_press  = inc_lvl & ~inc_prev;

    logic [PW-1:0] pcnt, pcnt_nx;
    logic [1:0]    mode_nx;
    logic [5:0]    hour_nx, minute_nx, second_nx;
    logic          tick_nx;

    always_comb begin
        pcnt_nx   = pcnt;
        mode_nx   = mode;
        hour_nx   = hour;
        minute_nx = minute;
        second_nx = second;

        if (mode == RUN) begin
            if (tick) begin
                pcnt_nx = '0;
                if (second == 6'd59) begin
                    second_nx = '0;
                    if (minute == 6'd59) begin
                        minute_nx = '0;
                        hour_nx   = (hour == 6'd23) ? 6'd0 : hour + 6'd1;
                    end else begin
                        minute_nx = minute + 6'd1;
                    end
                end else begin
                    second_nx = second + 6'd1;
                end
            end else begin
                pcnt_nx = pcnt + 1'b1;
            end
        end else begin
            pcnt_nx = '0;
        end

        // Mode change takes priority; a tick already applied above still stands.
        if (mode_press) begin
            mode_nx = mode + 2'd1;
            pcnt_nx = '0;
        end else if (inc_press) begin
            case (mode)
                SET_HOUR: hour_nx   = (hour   == 6'd23) ? 6'd0 : hour + 6'd1;
                SET_MIN:  minute_nx = (minute == 6'd59) ? 6'd0 : minute + 6'd1;
                SET_SEC:  second_nx = (second == 6'd59) ? 6'd0 : second + 6'd1;
                default:  ;
            endcase
        end

        // Registered tick: high in the cycle whose pcnt equals the last count, RUN only.
        tick_nx = (mode_nx == RUN) && (pcnt_nx == PCNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt   <= '0;
            mode   <= RUN;
            hour   <= '0;
            minute <= '0;
            second <= '0;
            tick   <= 1'b0;
        end else begin
            pcnt   <= pcnt_nx;
            mode   <= mode_nx;
            hour   <= hour_nx;
            minute <= minute_nx;
            second <= second_nx;
            tick   <= tick_nx;
        end
    end

endmodule
